// File: rtl/ysyx_23060191_axil_sram_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder.
package ysyx_23060191_axil_sram_pkg;

  localparam int unsigned CpuWidth = 32;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRdWait    = 3'd1,
    StRdResp    = 3'd2,
    StWrCollect = 3'd3,
    StWrWait    = 3'd4,
    StWrResp    = 3'd5
  } sram_state_e;

  // Limit is computed in 33 bits so a window touching 2**32 does not wrap.
  function automatic logic addr_hit(input logic [CpuWidth-1:0] addr,
                                    input logic [CpuWidth-1:0] base,
                                    input int unsigned         depth_log2);
    logic [CpuWidth:0] limit;
    limit = {1'b0, base} + (33'd4 << depth_log2);
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/ysyx_23060191_axil_sram_if.sv
// AXI4-Lite bus bundle between the LSU (master) and the SRAM responder (slave).
interface ysyx_23060191_axil_sram_if;
  import ysyx_23060191_axil_sram_pkg::*;

  logic [CpuWidth-1:0] araddr;
  logic                arvalid;
  logic                arready;
  logic [CpuWidth-1:0] rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [CpuWidth-1:0] awaddr;
  logic                awvalid;
  logic                awready;
  logic [CpuWidth-1:0] wdata;
  logic [3:0]          wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_23060191_sram_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read, no reset.
module ysyx_23060191_sram_array
  import ysyx_23060191_axil_sram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 16
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [CpuWidth-1:0]   i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [CpuWidth-1:0]   o_rdata
);

  logic [CpuWidth-1:0] r_mem [(1 << DEPTH_LOG2)];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_23060191_axil_sram.sv
// AXI4-Lite memory responder: one transaction at a time, fixed latency, OKAY/SLVERR.
module ysyx_23060191_axil_sram
  import ysyx_23060191_axil_sram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned LATENCY    = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_23060191_axil_sram_if.slave s_axil
);

  // Address phase counts as the first latency cycle, so the wait state lasts LATENCY cycles.
  localparam logic [3:0] LatLoad = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  sram_state_e         r_state;
  logic [3:0]          r_cnt;
  logic                r_arready, r_awready, r_wready;
  logic                r_aw_got, r_w_got;
  logic [CpuWidth-1:0] r_araddr, r_awaddr, r_wdata, r_rdata;
  logic [3:0]          r_wstrb;
  logic [1:0]          r_rresp, r_bresp;
  logic                r_rvalid, r_bvalid;

  logic                  w_arready;
  logic                  w_ar_hs, w_aw_hs, w_w_hs;
  logic                  w_wr_addr_done, w_rd_addr_done;
  logic                  w_wr_go, w_rd_go;
  logic [CpuWidth-1:0]   w_rd_addr, w_wr_addr, w_wr_data, w_arr_rdata;
  logic [3:0]            w_wr_strb;
  logic                  w_rd_hit, w_wr_hit, w_we;
  logic [DEPTH_LOG2-1:0] w_rd_idx, w_wr_idx;

  // Any write activity in IDLE blocks AR in the same cycle.
  assign w_arready = r_arready && !(s_axil.awvalid || s_axil.wvalid);

  always_comb begin
    w_ar_hs        = s_axil.arvalid && w_arready;
    w_aw_hs        = s_axil.awvalid && r_awready;
    w_w_hs         = s_axil.wvalid && r_wready;
    w_wr_addr_done = ((r_state == StIdle) || (r_state == StWrCollect)) &&
                     (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
    w_rd_addr_done = w_ar_hs;
    w_wr_go        = ((r_state == StWrWait) && (r_cnt == 4'd0)) ||
                     ((LATENCY == 0) && w_wr_addr_done);
    w_rd_go        = ((r_state == StRdWait) && (r_cnt == 4'd0)) ||
                     ((LATENCY == 0) && w_rd_addr_done);
    // Bypass the capture registers when the completing handshake is this cycle.
    w_wr_addr      = w_aw_hs ? s_axil.awaddr : r_awaddr;
    w_wr_data      = w_w_hs ? s_axil.wdata : r_wdata;
    w_wr_strb      = w_w_hs ? s_axil.wstrb : r_wstrb;
    w_rd_addr      = w_ar_hs ? s_axil.araddr : r_araddr;
    w_rd_hit       = addr_hit(w_rd_addr, ADDR_BASE, DEPTH_LOG2);
    w_wr_hit       = addr_hit(w_wr_addr, ADDR_BASE, DEPTH_LOG2);
    w_rd_idx       = DEPTH_LOG2'((w_rd_addr - ADDR_BASE) >> 2);
    w_wr_idx       = DEPTH_LOG2'((w_wr_addr - ADDR_BASE) >> 2);
    w_we           = w_wr_go && w_wr_hit && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_arready <= 1'b1;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= 4'd0;
      r_rdata   <= '0;
      r_rresp   <= AxiRespOkay;
      r_bresp   <= AxiRespOkay;
      r_rvalid  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StWrCollect: begin
          if (w_aw_hs) begin
            r_awaddr  <= s_axil.awaddr;
            r_aw_got  <= 1'b1;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= s_axil.wdata;
            r_wstrb  <= s_axil.wstrb;
            r_w_got  <= 1'b1;
            r_wready <= 1'b0;
          end
          if (w_wr_addr_done) begin
            r_arready <= 1'b0;
            if (w_wr_go) begin
              r_state  <= StWrResp;
              r_bvalid <= 1'b1;
              r_bresp  <= w_wr_hit ? AxiRespOkay : AxiRespSlverr;
            end else begin
              r_state <= StWrWait;
              r_cnt   <= LatLoad;
            end
          end else if (w_aw_hs || w_w_hs) begin
            r_arready <= 1'b0;
            r_state   <= StWrCollect;
          end else if (w_rd_addr_done) begin
            r_araddr  <= s_axil.araddr;
            r_arready <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            if (w_rd_go) begin
              r_state  <= StRdResp;
              r_rvalid <= 1'b1;
              r_rdata  <= w_rd_hit ? w_arr_rdata : '0;
              r_rresp  <= w_rd_hit ? AxiRespOkay : AxiRespSlverr;
            end else begin
              r_state <= StRdWait;
              r_cnt   <= LatLoad;
            end
          end
        end
        StRdWait: begin
          if (w_rd_go) begin
            r_state  <= StRdResp;
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_hit ? w_arr_rdata : '0;
            r_rresp  <= w_rd_hit ? AxiRespOkay : AxiRespSlverr;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StWrWait: begin
          if (w_wr_go) begin
            r_state  <= StWrResp;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_hit ? AxiRespOkay : AxiRespSlverr;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StRdResp: begin
          if (s_axil.rready) begin
            r_rvalid  <= 1'b0;
            r_state   <= StIdle;
            r_arready <= 1'b1;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        StWrResp: begin
          if (s_axil.bready) begin
            r_bvalid  <= 1'b0;
            r_state   <= StIdle;
            r_arready <= 1'b1;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  ysyx_23060191_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_be   (w_wr_strb),
    .i_waddr(w_wr_idx),
    .i_wdata(w_wr_data),
    .i_raddr(w_rd_idx),
    .o_rdata(w_arr_rdata)
  );

  assign s_axil.arready = w_arready;
  assign s_axil.awready = r_awready;
  assign s_axil.wready  = r_wready;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rdata   = r_rdata;
  assign s_axil.rresp   = r_rresp;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = r_bresp;

endmodule

// File: tb/tb_ysyx_23060191_axil_sram.sv
// Scoreboard bench for the AXI4-Lite SRAM responder: directed transactions, queued expectations.
module tb_ysyx_23060191_axil_sram;

  localparam int unsigned Lat = 2;
  localparam logic [1:0]  Okay = 2'b00;
  localparam logic [1:0]  Serr = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060191_axil_sram_if bus ();

  ysyx_23060191_axil_sram #(
    .ADDR_BASE (32'h8000_0000),
    .DEPTH_LOG2(16),
    .LATENCY   (Lat)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axil(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] rd_q[$];
  logic [1:0]  wr_q[$];
  logic [33:0] r_exp;
  logic [1:0]  b_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed R/B handshake is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rvalid && bus.rready) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL r_unexpected: got rdata %h, expected no response", bus.rdata);
        end else begin
          r_exp = rd_q.pop_front();
          check("rdata", bus.rdata, r_exp[33:2]);
          check("rresp", {30'd0, bus.rresp}, {30'd0, r_exp[1:0]});
        end
      end
      if (!rst && bus.bvalid && bus.bready) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: got bresp %h, expected no response", bus.bresp);
        end else begin
          b_exp = wr_q.pop_front();
          check("bresp", {30'd0, bus.bresp}, {30'd0, b_exp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold,
                          input logic [1:0] exp);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int c = 0, lat = 0;
    wr_q.push_back(exp);
    bus.bready = (hold == 0);
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid = !aw_done && (c >= aw_dly);
      bus.wvalid  = !w_done && (c >= w_dly);
      @(negedge clk);
      if (w_done && !aw_done) check("wready_low", bus.wready, 0);
      if (aw_done && !w_done) check("awready_low", bus.awready, 0);
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      @(posedge clk);
      #1;
      aw_done = aw_done || aw_now;
      w_done  = w_done || w_now;
      c++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("aw_w_accept", aw_done && w_done, 1);
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.bvalid && lat < 40);
    check("b_latency", lat, Lat + 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bvalid_hold", bus.bvalid, 1);
      check("bresp_hold", bus.bresp, exp);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      bus.bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int hold);
    bit got = 0;
    int c = 0, lat = 0;
    rd_q.push_back({exp_data, exp_resp});
    bus.rready  = (hold == 0);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!got && c < 40) begin
      @(negedge clk);
      got = bus.arready;
      @(posedge clk);
      #1;
      c++;
    end
    bus.arvalid = 1'b0;
    check("ar_accept", got, 1);
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rvalid && lat < 40);
    check("r_latency", lat, Lat + 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rvalid_hold", bus.rvalid, 1);
      check("rdata_hold", bus.rdata, exp_data);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      bus.rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rvalid"}, bus.rvalid, 0);
    check({tag, "_bvalid"}, bus.bvalid, 0);
    check({tag, "_arready"}, bus.arready, 1);
    check({tag, "_awready"}, bus.awready, 1);
    check({tag, "_wready"}, bus.wready, 1);
  endtask

  initial begin
    int c;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = 4'h0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check("rst_rdata", bus.rdata, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_bresp", bus.bresp, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic write then read-back, plus sub-word address bits ignored.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, Okay);
    do_read(32'h8000_0010, 32'hDEAD_BEEF, Okay, 0);
    do_read(32'h8000_0013, 32'hDEAD_BEEF, Okay, 0);

    // Byte-lane merge and the all-zero strobe no-op.
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, 0, Okay);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, Okay);
    do_read(32'h8000_0020, 32'h11BB_33DD, Okay, 0);
    do_write(32'h8000_0010, 32'h0000_0000, 4'h0, 0, 0, 0, Okay);
    do_read(32'h8000_0010, 32'hDEAD_BEEF, Okay, 0);

    // Decode boundaries: below base, one past the top, and the last word.
    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, Okay);
    do_read(32'h7FFF_FFFC, 32'h0000_0000, Serr, 0);
    do_write(32'h8004_0000, 32'h1234_5678, 4'hF, 0, 0, 0, Serr);
    do_read(32'h8000_0000, 32'hCAFE_F00D, Okay, 0);
    do_write(32'h8003_FFFC, 32'h5A5A_5A5A, 4'hF, 0, 0, 0, Okay);
    do_read(32'h8003_FFFC, 32'h5A5A_5A5A, Okay, 0);

    // W ahead of AW, and responses stalled by a slow master.
    do_write(32'h8000_0030, 32'h0102_0304, 4'hF, 3, 0, 5, Okay);
    do_read(32'h8000_0030, 32'h0102_0304, Okay, 5);

    // Simultaneous AR and AW+W: write wins, read sees the new data.
    wr_q.push_back(Okay);
    bus.araddr  = 32'h8000_0040;
    bus.arvalid = 1'b1;
    bus.awaddr  = 32'h8000_0040;
    bus.wdata   = 32'hFEED_C0DE;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(negedge clk);
    check("t5_arready_low", bus.arready, 0);
    check("t5_awready", bus.awready, 1);
    check("t5_wready", bus.wready, 1);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      check("t5_arready_wait", bus.arready, 0);
      c++;
    end while (!bus.bvalid && c < 40);
    check("t5_b_latency", c, Lat + 1);
    rd_q.push_back({32'hFEED_C0DE, Okay});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_arready_idle", bus.arready, 1);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.rvalid && c < 40);
    check("t5_r_latency", c, Lat + 1);
    @(posedge clk);
    #1;

    // Reset during a read wait: no response may follow.
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6r");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6r_no_rvalid", bus.rvalid, 0);
    @(posedge clk);
    #1;

    // Reset during a write wait: the write must not land.
    bus.awaddr  = 32'h8000_0010;
    bus.wdata   = 32'h0BAD_0BAD;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6w");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6w_no_bvalid", bus.bvalid, 0);
    @(posedge clk);
    #1;
    do_read(32'h8000_0010, 32'hDEAD_BEEF, Okay, 0);

    repeat (2) @(posedge clk);
    check("rd_q_empty", rd_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
